mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width of the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width; only 32 is supported.
REQ-003 SHALL have parameter TRANSFER_WIDTH, default 4, byte-lane enable width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req_valid_i, input, 1 bit, and req_ready_o, output, 1 bit: request handshake.
REQ-007 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 invalid.
REQ-009 SHALL have port req_unsigned_i, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 SHALL have ports req_addr_i, input, ADDR_WIDTH bits, and req_wdata_i, input, 32 bits: byte address and store data, right-justified.
REQ-011 SHALL have ports rsp_valid_o, output, 1 bit; rsp_rdata_o, output, 32 bits; rsp_err_o, output, 1 bit: completion pulse, load result, error flag.
REQ-012 SHALL have ports mem_addr_o, output, ADDR_WIDTH bits; mem_we_o, output, 1 bit; mem_data_o, output, 32 bits; mem_transfer_o, output, TRANSFER_WIDTH bits: initiator side of one data-memory port.
REQ-013 SHALL have port mem_data_i, input, 32 bits: memory read data, valid combinationally in the same cycle when mem_we_o = 0.

Function
REQ-014 SHALL implement FSM states IDLE, ACC1, ACC2, RESP.
REQ-015 SHALL drive req_ready_o = 1 only in IDLE; a request is accepted on a rising edge with req_valid_i && req_ready_o, and all request fields are registered then.
REQ-016 SHALL transition IDLE->ACC1 on accept; ACC1->ACC2 if the access crosses a word boundary (offset + size bytes > 4), else ACC1->RESP; ACC2->RESP; RESP->IDLE unconditionally.
REQ-017 SHALL drive mem_addr_o = word-aligned address (addr & ~3) in ACC1 and ((addr & ~3) + 4) modulo 2^ADDR_WIDTH in ACC2.
REQ-018 SHALL drive stores with mem_we_o = 1, store bytes shifted to lane (offset + i) mod 4, and mem_transfer_o set only for the lanes written in that access (ACC1: lanes offset..min(offset+size-1, 3); ACC2: remaining lanes starting at 0).
REQ-019 SHALL drive loads with mem_we_o = 0 and mem_transfer_o = 0, capturing mem_data_i at the end of ACC1 and ACC2, and assembling bytes in address order into rsp_rdata_o.
REQ-020 SHALL extend byte and half loads per req_unsigned_i; for word loads, req_unsigned_i SHALL be ignored; for stores, rsp_rdata_o SHALL be 0.
REQ-021 SHALL assert rsp_valid_o for exactly one cycle, in RESP; rsp_rdata_o and rsp_err_o are valid in that cycle and hold until the next RESP.
REQ-022 SHALL handle size 11 by going IDLE->RESP directly with rsp_err_o = 1 and no memory access.
REQ-023 SHALL drive mem_we_o = 0, mem_transfer_o = 0, mem_addr_o = 0, mem_data_o = 0 outside ACC1/ACC2.
REQ-024 SHALL give latency from accept edge to rsp_valid_o of 2 cycles for a single access and 3 cycles for a split access.

Reset
REQ-025 SHALL, on rst high at a rising edge, enter IDLE from any state, abandon any in-flight access without a response, and set rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, and all mem_* outputs = 0.

Configuration
REQ-026 SHALL support macro LSU_MISALIGN_EN: when defined, accesses not naturally aligned SHALL proceed (single or split per REQ-016).
REQ-027 SHALL, when LSU_MISALIGN_EN is undefined, route any half access with addr[0] = 1 or word access with addr[1:0] != 0 to RESP with rsp_err_o = 1 and no memory access; ACC2 is then unreachable.

Verification
REQ-028 SHALL cover: store word 0xDEADBEEF @0x010 -> ACC1 mem_addr 0x010, transfer 1111; load word @0x010 two cycles later -> rsp_rdata 0xDEADBEEF.
REQ-029 SHALL cover: store byte 0x80 @0x013 -> transfer 1000, mem_data[31:24] = 0x80; load byte signed @0x013 -> 0xFFFFFF80; load byte unsigned @0x013 -> 0x00000080.
REQ-030 SHALL cover, with LSU_MISALIGN_EN defined: store word 0x11223344 @0x006 -> ACC1 addr 0x004, transfer 1100; ACC2 addr 0x008, transfer 0011; load word @0x006 -> 0x11223344, latency 3.
REQ-031 SHALL cover, with LSU_MISALIGN_EN defined: load half @0x3FF with word 0x3FC = 0xAB000000 and word 0x000 = 0x000000CD -> ACC2 addr 0x000 (wrap), rsp_rdata 0xFFFFCDAB.
REQ-032 SHALL cover, without LSU_MISALIGN_EN: load word @0x006 -> rsp_err 1 one cycle after accept, mem_we/transfer stay 0; size 11 -> rsp_err 1.
REQ-033 SHALL cover: rst asserted during ACC2 of a split store -> next cycle IDLE, req_ready 1, no rsp_valid, and second-word memory contents unchanged.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit driving one 32-bit data-memory port; word-crossing accesses take two beats.
// Define LSU_MISALIGN_EN to let misaligned half/word accesses proceed instead of erroring.
module mem_lsu #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TRANSFER_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_data_o,
    output logic [TRANSFER_WIDTH-1:0] mem_transfer_o,
    input  logic [DATA_WIDTH-1:0]     mem_data_i
);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rd0_q, rd0_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  misalign_err;
    logic                  req_err;
    logic [1:0]            off;
    logic [2:0]            nbytes;
    logic [3:0]            mask_n;
    logic [7:0]            lane_mask;
    logic                  split;
    logic [31:0]           wdata_rot;
    logic [31:0]           lo_word;
    logic [63:0]           pair_shr;
    logic [31:0]           raw;
    logic [31:0]           load_val;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  mem_we_c;
    logic [31:0]           mem_data_c;
    logic [3:0]            mem_transfer_c;

`ifdef LSU_MISALIGN_EN
    assign misalign_err = 1'b0;
`else
    assign misalign_err = (req_size_i == 2'b01 && req_addr_i[0]) ||
                          (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
`endif
    assign req_err = (req_size_i == 2'b11) || misalign_err;

    assign off       = addr_q[1:0];
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        nbytes = 3'd4;
        mask_n = 4'b1111;
        unique case (size_q)
            2'b00:   begin nbytes = 3'd1; mask_n = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask_n = 4'b0011; end
            default: begin nbytes = 3'd4; mask_n = 4'b1111; end
        endcase
    end

    assign split     = ({1'b0, off} + nbytes) > 3'd4;
    // Low nibble: lanes of the first word; high nibble: lanes spilling into the next word.
    assign lane_mask = {4'b0000, mask_n} << off;

    always_comb begin
        wdata_rot = wdata_q;
        unique case (off)
            2'd0: wdata_rot = wdata_q;
            2'd1: wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
            2'd2: wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
            2'd3: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
            default: wdata_rot = wdata_q;
        endcase
    end

    // Bytes in address order: first word in the low half, second word in the high half.
    assign lo_word  = (state_q == StAcc2) ? rd0_q : mem_data_i[31:0];
    assign pair_shr = {mem_data_i[31:0], lo_word} >> {off, 3'b000};
    assign raw      = pair_shr[31:0];

    always_comb begin
        load_val = raw;
        unique case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   load_val = uns_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: load_val = raw;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        uns_d          = uns_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd0_d          = rd0_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        mem_addr_c     = '0;
        mem_we_c       = 1'b0;
        mem_data_c     = 32'h0;
        mem_transfer_c = 4'b0000;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (req_err) begin
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d = StAcc1;
                    end
                end
            end
            StAcc1: begin
                mem_addr_c     = word_addr;
                mem_we_c       = we_q;
                mem_data_c     = we_q ? wdata_rot : 32'h0;
                mem_transfer_c = we_q ? lane_mask[3:0] : 4'b0000;
                rd0_d          = mem_data_i[31:0];
                if (split) begin
                    state_d = StAcc2;
                end else begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'h0 : load_val;
                end
            end
            StAcc2: begin
                mem_addr_c     = word_addr + ADDR_WIDTH'(4);
                mem_we_c       = we_q;
                mem_data_c     = we_q ? wdata_rot : 32'h0;
                mem_transfer_c = we_q ? lane_mask[7:4] : 4'b0000;
                state_d        = StResp;
                rsp_err_d      = 1'b0;
                rsp_rdata_d    = we_q ? 32'h0 : load_val;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset also blanks the port so an abandoned beat never reaches the memory.
    assign mem_addr_o     = rst ? '0 : mem_addr_c;
    assign mem_we_o       = mem_we_c & ~rst;
    assign mem_data_o     = rst ? '0 : mem_data_c;
    assign mem_transfer_o = rst ? '0 : mem_transfer_c;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rd0_q       <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd0_q       <= rd0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-array reference model plus response scoreboard, with a word RAM on the port.
// Misaligned-path scenarios follow LSU_MISALIGN_EN the same way the design does.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [9:0]  req_addr_i = 10'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [9:0]  mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_transfer_o;
    logic [31:0] mem_data_i;

    int total = 0;
    int bad = 0;

    logic [31:0] ram [256] = '{default: 32'h0};
    logic [7:0]  rmem [1024] = '{default: 8'h00};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } exp_t;
    exp_t sb[$];

    logic [9:0]  tr_addr [4];
    logic        tr_we [4];
    logic [3:0]  tr_tr [4];
    logic [31:0] tr_data [4];

    mem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_data_o     (mem_data_o),
        .mem_transfer_o (mem_transfer_o),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk = ~clk;

    assign mem_data_i = ram[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_transfer_o[l]) ram[mem_addr_o[9:2]][8*l +: 8] <= mem_data_o[8*l +: 8];
            end
        end
    end

    function automatic int nb(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [9:0] addr);
        if (size == 2'b11) return 1'b1;
`ifndef LSU_MISALIGN_EN
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [9:0] addr);
        logic [31:0] v = 32'h0;
        int n = nb(size);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[(int'(addr) + i) % 1024];
        if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata);
        exp_t e;
        int n = 0;
        int lat_seen = 0;
        logic got = 1'b0;
        e.err   = model_err(size, addr);
        e.rdata = (e.err || we) ? 32'h0 : model_load(size, uns, addr);
        e.lat   = e.err ? 4'd1 : ((int'(addr[1:0]) + nb(size) > 4) ? 4'd3 : 4'd2);
        if (we && !e.err) begin
            for (int i = 0; i < nb(size); i++) rmem[(int'(addr) + i) % 1024] = wdata[8*i +: 8];
        end
        sb.push_back(e);
        for (int c = 0; c < 4; c++) begin
            tr_addr[c] = 10'h0; tr_we[c] = 1'b0; tr_tr[c] = 4'h0; tr_data[c] = 32'h0;
        end
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata;
        while (!req_ready_o && n < 10) begin @(posedge clk); #1; n++; end
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("FAIL %s ready: got %b want 1", tag, req_ready_o);
        end
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) req_valid_i = 1'b0;
            if (c <= 4) begin
                tr_addr[c-1] = mem_addr_o; tr_we[c-1] = mem_we_o;
                tr_tr[c-1] = mem_transfer_o; tr_data[c-1] = mem_data_o;
            end
            if (rsp_valid_o === 1'b1) begin got = 1'b1; lat_seen = c; end
        end
        e = sb.pop_front();
        total++;
        if (!got) begin
            bad++; $display("FAIL %s rsp_valid timeout: got none want pulse", tag);
        end else begin
            if (rsp_rdata_o !== e.rdata) begin
                bad++; $display("FAIL %s rdata: got %h want %h", tag, rsp_rdata_o, e.rdata);
            end
            total++;
            if (rsp_err_o !== e.err) begin
                bad++; $display("FAIL %s err: got %b want %b", tag, rsp_err_o, e.err);
            end
            total++;
            if (lat_seen != int'(e.lat)) begin
                bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat_seen, e.lat);
            end
            @(posedge clk); #1;
            total++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_rdata_o !== e.rdata) begin
                bad++;
                $display("FAIL %s after-resp: got valid=%b ready=%b rdata=%h want 0 1 %h", tag,
                         rsp_valid_o, req_ready_o, rsp_rdata_o, e.rdata);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({mem_we_o, mem_transfer_o, mem_addr_o, mem_data_o} !== 47'h0) begin
            bad++; $display("FAIL reset_mem: got we=%b tr=%b addr=%h data=%h want all 0",
                            mem_we_o, mem_transfer_o, mem_addr_o, mem_data_o);
        end
        total++;
        if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
            bad++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0 0 0",
                            rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        rst = 1'b0;
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_word();
        do_req("st_word", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
        total++;
        if (tr_addr[0] !== 10'h010 || tr_tr[0] !== 4'b1111 || tr_we[0] !== 1'b1 ||
            tr_data[0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL st_word_port: got addr=%h tr=%b we=%b data=%h want 010 1111 1 deadbeef",
                            tr_addr[0], tr_tr[0], tr_we[0], tr_data[0]);
        end
        do_req("ld_word", 1'b0, 2'b10, 1'b1, 10'h010, 32'h0);
        total++;
        if (tr_we[0] !== 1'b0 || tr_tr[0] !== 4'b0000 || rsp_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL ld_word_port: got we=%b tr=%b rdata=%h want 0 0000 deadbeef",
                            tr_we[0], tr_tr[0], rsp_rdata_o);
        end
    endtask

    task automatic test_byte();
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 10'h013, 32'h00000080);
        total++;
        if (tr_tr[0] !== 4'b1000 || tr_data[0][31:24] !== 8'h80) begin
            bad++; $display("FAIL st_byte_port: got tr=%b lane3=%h want 1000 80",
                            tr_tr[0], tr_data[0][31:24]);
        end
        do_req("ld_byte_s", 1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
        total++;
        if (rsp_rdata_o !== 32'hFFFFFF80) begin
            bad++; $display("FAIL ld_byte_s_val: got %h want ffffff80", rsp_rdata_o);
        end
        do_req("ld_byte_u", 1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
        total++;
        if (rsp_rdata_o !== 32'h00000080) begin
            bad++; $display("FAIL ld_byte_u_val: got %h want 00000080", rsp_rdata_o);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_EN
        do_req("st_split", 1'b1, 2'b10, 1'b0, 10'h006, 32'h11223344);
        total++;
        if (tr_addr[0] !== 10'h004 || tr_tr[0] !== 4'b1100 || tr_data[0][31:16] !== 16'h3344 ||
            tr_addr[1] !== 10'h008 || tr_tr[1] !== 4'b0011 || tr_data[1][15:0] !== 16'h1122) begin
            bad++; $display("FAIL st_split_port: got %h/%b/%h %h/%b/%h want 004/1100/3344 008/0011/1122",
                            tr_addr[0], tr_tr[0], tr_data[0], tr_addr[1], tr_tr[1], tr_data[1]);
        end
        do_req("ld_split", 1'b0, 2'b10, 1'b0, 10'h006, 32'h0);
        do_req("st_hi", 1'b1, 2'b10, 1'b0, 10'h3FC, 32'hAB000000);
        do_req("st_lo", 1'b1, 2'b10, 1'b0, 10'h000, 32'h000000CD);
        do_req("ld_wrap", 1'b0, 2'b01, 1'b0, 10'h3FF, 32'h0);
        total++;
        if (tr_addr[0] !== 10'h3FC || tr_addr[1] !== 10'h000 || rsp_rdata_o !== 32'hFFFFCDAB) begin
            bad++; $display("FAIL ld_wrap_port: got %h %h %h want 3fc 000 ffffcdab",
                            tr_addr[0], tr_addr[1], rsp_rdata_o);
        end
`else
        do_req("ld_misal", 1'b0, 2'b10, 1'b0, 10'h006, 32'h0);
        total++;
        if (tr_we[0] !== 1'b0 || tr_tr[0] !== 4'b0000 || tr_addr[0] !== 10'h0) begin
            bad++; $display("FAIL ld_misal_port: got we=%b tr=%b addr=%h want 0 0000 000",
                            tr_we[0], tr_tr[0], tr_addr[0]);
        end
        do_req("st_misal_half", 1'b1, 2'b01, 1'b0, 10'h011, 32'h0000BEEF);
`endif
        do_req("size11", 1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] wd = 32'h55667788;
        int w;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_wdata_i = wd;
`ifdef LSU_MISALIGN_EN
        req_addr_i = 10'h00A;
        w = 3;
`else
        req_addr_i = 10'h00C;
        w = 3;
`endif
        @(posedge clk); #1;
        req_valid_i = 1'b0;
`ifdef LSU_MISALIGN_EN
        @(posedge clk); #1;
        rmem[10'h00A] = wd[7:0];
        rmem[10'h00B] = wd[15:8];
`endif
        total++;
        if (mem_we_o !== 1'b1) begin
            bad++; $display("FAIL abort_in_access: got we=%b want 1", mem_we_o);
        end
        rst = 1'b1; #1;
        total++;
        if (mem_we_o !== 1'b0 || mem_transfer_o !== 4'b0000) begin
            bad++; $display("FAIL abort_gate: got we=%b tr=%b want 0 0000", mem_we_o, mem_transfer_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
            rsp_err_o !== 1'b0) begin
            bad++; $display("FAIL abort_state: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                            req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        total++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b0) begin
                bad++; $display("FAIL abort_no_rsp: got valid=%b at cycle %0d want 0", rsp_valid_o, c);
                break;
            end
        end
        total++;
        if (ram[w] !== ref_word(w) || ram[2] !== ref_word(2)) begin
            bad++; $display("FAIL abort_mem: got %h %h want %h %h",
                            ram[2], ram[w], ref_word(2), ref_word(w));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom);
        end
    endtask

    task automatic test_mem_image();
        int miss = 0;
        for (int w = 0; w < 256; w++) begin
            if (ram[w] !== ref_word(w)) begin
                if (miss == 0) $display("FAIL mem_image word %0d: got %h want %h", w, ram[w], ref_word(w));
                miss++;
            end
        end
        total++;
        if (miss != 0) bad++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_reset_abort();
        test_random();
        test_mem_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
